// File: rtl/bcd_time_display_scanner.sv
// bcd_time_display_scanner
//   Drives a 6-digit multiplexed 7-segment display from the 12-hour BCD time bus.
//   One digit is active per scan slot of SCAN_DIV clocks. The time is copied into a
//   shadow register once per frame (on the last slot's tick) so a whole frame shows
//   one coherent time. The hour tens digit is blanked when zero, PM lights the decimal
//   point of the hour ones digit, and any snapshot holding a non-BCD nibble sets a
//   sticky error flag.
// Ports
//   clk     in  1  system clock, posedge
//   reset   in  1  synchronous, active-high
//   hh      in  8  hours BCD {tens,ones}
//   mm      in  8  minutes BCD
//   ss      in  8  seconds BCD
//   pm      in  1  1 = PM
//   freeze  in  1  1 = skip the next frame reload
//   an      out 6  one-hot digit enable, an[0]=ss ones .. an[5]=hh tens
//   seg     out 7  segments {g,f,e,d,c,b,a}
//   dp      out 1  decimal point of the active digit
//   err     out 1  sticky invalid-BCD flag
module bcd_time_display_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  input  logic       freeze,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       err
);

  localparam int unsigned   CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  // Inactive levels double as XOR masks converting active-high codes to the pin polarity.
  localparam logic [5:0] AN_OFF  = SEG_ACTIVE_LOW ? 6'h3F : 6'h00;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_d;
  logic [7:0]    r_sh_hh;
  logic [7:0]    r_sh_mm;
  logic [7:0]    r_sh_ss;
  logic          r_sh_pm;
  logic          r_err;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_tick;
  logic          w_snap;
  logic          w_bad_in;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg_hi;
  logic [5:0]    w_an_hi;
  logic          w_dp_hi;

  function automatic logic [6:0] f_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h79;
    endcase
    return s;
  endfunction

  function automatic logic f_bad(input logic [7:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  assign w_tick   = (r_cnt == CNT_LAST);
  assign w_snap   = w_tick && (r_d == 3'd5) && !freeze;
  assign w_bad_in = f_bad(hh) || f_bad(mm) || f_bad(ss);

  always_comb begin
    w_nib    = 4'd0;
    w_seg_hi = 7'h00;
    w_an_hi  = 6'd1 << r_d;
    w_dp_hi  = 1'b0;
    case (r_d)
      3'd0:    w_nib = r_sh_ss[3:0];
      3'd1:    w_nib = r_sh_ss[7:4];
      3'd2:    w_nib = r_sh_mm[3:0];
      3'd3:    w_nib = r_sh_mm[7:4];
      3'd4:    w_nib = r_sh_hh[3:0];
      3'd5:    w_nib = r_sh_hh[7:4];
      default: w_nib = 4'd0;
    endcase
    w_seg_hi = f_seg(w_nib);
    // Leading-zero blanking of hour tens; the digit enable stays on.
    if ((r_d == 3'd5) && (r_sh_hh[7:4] == 4'd0)) begin
      w_seg_hi = 7'h00;
    end
    if ((r_d == 3'd4) && r_sh_pm) begin
      w_dp_hi = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_d     <= '0;
      r_sh_hh <= '0;
      r_sh_mm <= '0;
      r_sh_ss <= '0;
      r_sh_pm <= 1'b0;
      r_err   <= 1'b0;
      r_an    <= AN_OFF;
      r_seg   <= SEG_OFF;
      r_dp    <= DP_OFF;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_d <= (r_d == 3'd5) ? 3'd0 : r_d + 3'd1;
      end
      if (w_snap) begin
        r_sh_hh <= hh;
        r_sh_mm <= mm;
        r_sh_ss <= ss;
        r_sh_pm <= pm;
        if (w_bad_in) begin
          r_err <= 1'b1;
        end
      end
      r_an  <= w_an_hi ^ AN_OFF;
      r_seg <= w_seg_hi ^ SEG_OFF;
      r_dp  <= w_dp_hi ^ DP_OFF;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;
  assign err = r_err;

endmodule

// File: tb/tb_bcd_time_display_scanner.sv
module tb_bcd_time_display_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hh, mm, ss;
  logic       pm, freeze;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp, err;

  int n_cmp = 0;
  int n_bad = 0;
  int ecount = 0;

  bcd_time_display_scanner #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .hh(hh), .mm(mm), .ss(ss), .pm(pm), .freeze(freeze),
    .an(an), .seg(seg), .dp(dp), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      hh, mm, ss;
    logic            pm, frz;
    logic [0:5][6:0] s;    // expected seg for d0..d5
    logic            dpx;  // expected dp on d4
    logic            e;    // expected err
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic goto(input int e);
    while (ecount < e) tick();
  endtask

  initial begin
    vecs[0] = '{8'h12, 8'h34, 8'h56, 1'b1, 1'b0, {7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06}, 1'b1, 1'b0};
    vecs[1] = '{8'h03, 8'h34, 8'h56, 1'b0, 1'b0, {7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h4F, 7'h00}, 1'b0, 1'b0};
    vecs[2] = '{8'h12, 8'h34, 8'h57, 1'b1, 1'b1, {7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h4F, 7'h00}, 1'b0, 1'b0};
    vecs[3] = '{8'h12, 8'h34, 8'h57, 1'b1, 1'b0, {7'h07, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06}, 1'b1, 1'b0};
    vecs[4] = '{8'h13, 8'h00, 8'h09, 1'b0, 1'b0, {7'h6F, 7'h3F, 7'h3F, 7'h3F, 7'h4F, 7'h06}, 1'b0, 1'b0};
    vecs[5] = '{8'h10, 8'h59, 8'h5A, 1'b1, 1'b0, {7'h79, 7'h6D, 7'h6F, 7'h6D, 7'h3F, 7'h06}, 1'b1, 1'b1};
    vecs[6] = '{8'h11, 8'h22, 8'h59, 1'b0, 1'b0, {7'h6F, 7'h6D, 7'h5B, 7'h5B, 7'h06, 7'h06}, 1'b0, 1'b1};
    vecs[7] = '{8'h07, 8'h48, 8'h10, 1'b1, 1'b0, {7'h3F, 7'h06, 7'h7F, 7'h66, 7'h07, 7'h00}, 1'b1, 1'b1};

    reset = 1'b1; hh = 8'h12; mm = 8'h34; ss = 8'h56; pm = 1'b1; freeze = 1'b0;
    repeat (3) tick();
    chk("reset_an", 32'(an), 32'h00);
    chk("reset_seg", 32'(seg), 32'h00);
    chk("reset_dp", 32'(dp), 32'h0);
    chk("reset_err", 32'(err), 32'h0);

    // Release: edge 1 shows d0 of the zero shadow; each slot lasts 4 edges.
    reset = 1'b0;
    ecount = 0;
    tick();
    chk("rel_an_e1", 32'(an), 32'h01);
    chk("rel_seg_e1", 32'(seg), 32'h3F);
    goto(4);
    chk("rel_an_e4", 32'(an), 32'h01);
    goto(5);
    chk("rel_an_e5", 32'(an), 32'h02);
    goto(21);
    chk("rel_an_e21", 32'(an), 32'h20);
    chk("rel_seg_blank", 32'(seg), 32'h00);

    // Frame f shows the snapshot taken at edge 24f; slot j occupies edges 24f+4j+1..+4.
    for (int unsigned f = 1; f <= 8; f++) begin
      goto(24 * f - 2);
      hh = vecs[f-1].hh; mm = vecs[f-1].mm; ss = vecs[f-1].ss;
      pm = vecs[f-1].pm; freeze = vecs[f-1].frz;
      for (int unsigned j = 0; j < 6; j++) begin
        goto(24 * f + 4 * j + 2);
        chk($sformatf("v%0d_an_d%0d", f - 1, j), 32'(an), 32'(6'd1 << j));
        chk($sformatf("v%0d_seg_d%0d", f - 1, j), 32'(seg), 32'(vecs[f-1].s[j]));
        chk($sformatf("v%0d_dp_d%0d", f - 1, j), 32'(dp), 32'((j == 4) && vecs[f-1].dpx));
        if (j == 0) chk($sformatf("v%0d_err", f - 1), 32'(err), 32'(vecs[f-1].e));
      end
    end
    freeze = 1'b0;

    // Reset pulse while d=3, cnt=2 (frame-relative edge 14).
    goto(24 * 9 + 14);
    reset = 1'b1;
    tick();
    chk("mid_rst_an", 32'(an), 32'h00);
    chk("mid_rst_seg", 32'(seg), 32'h00);
    chk("mid_rst_dp", 32'(dp), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    reset = 1'b0;
    ecount = 0;
    tick();
    chk("post_an_e1", 32'(an), 32'h01);
    chk("post_seg_e1", 32'(seg), 32'h3F);
    goto(4);
    chk("post_an_e4", 32'(an), 32'h01);
    chk("post_err", 32'(err), 32'h0);
    goto(5);
    chk("post_an_e5", 32'(an), 32'h02);
    chk("post_seg_e5", 32'(seg), 32'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
